decoder_onehot_seq: RTL and testbench
=====================================

Name: decoder_onehot_seq

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready input handshake and three output modes: latched, timed pulse, and free-running scan.
- Successor to the combinational 3-to-8 decoder. Drives partial-product row/column enables and test-strobe lines in the Vedic multiplier datapath and its debug harness.
- All outputs are registered. There is no combinational path from input to output.

Parameters:
- SEL_W, 3, select width; output width OUT_W = 2**SEL_W (derived localparam, not overridable).
- PULSE_LEN, 4, cycles an output bit stays high in pulse mode and dwell time per position in scan mode; legal range 1..255.
- CNT_W, 8, width of the dwell/pulse counter; must satisfy 2**CNT_W > PULSE_LEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; low forces outputs to zero and the FSM to IDLE.
- mode  input  2  00 latch, 01 pulse, 10 scan, 11 reserved (treated as 00).
- sel  input  SEL_W  index to decode; bit i of out corresponds to sel == i.
- in_valid  input  1  sel is valid this cycle.
- in_ready  output  1  block can accept sel this cycle.
- out  output  OUT_W  one-hot decoded output, registered.
- out_idx  output  SEL_W  binary index of the asserted out bit; 0 when out == 0.
- out_active  output  1  high when out != 0.

Behaviour:
- Reset (rst_n low, async): out = 0, out_idx = 0, out_active = 0, in_ready = 0, counter = 0, state = IDLE. in_ready goes high on the first clock after reset release if en = 1 and mode != 10.
- States: IDLE, HOLD, PULSE, SCAN.
- Accept condition: in_valid && in_ready at a rising edge. The accepted sel appears on out on that same edge (1-cycle latency from sampling). out is always one-hot or zero.
- in_ready is registered. It is high in IDLE and HOLD when en = 1 and mode ∈ {00, 01, 11}. It is low in PULSE, in SCAN, and whenever en = 0.
- Latch mode (00/11):
  - IDLE or HOLD: on accept, out = onehot(sel) → HOLD.
  - HOLD keeps out unchanged until the next accept, which replaces it with no zero gap.
  - Back-to-back accepts every cycle are legal.
- Pulse mode (01):
  - On accept: out = onehot(sel), counter = PULSE_LEN-1 → PULSE.
  - Each cycle in PULSE: if counter == 0, out = 0 → IDLE; else counter decrements.
  - Net effect: out is high for exactly PULSE_LEN cycles.
  - in_ready rises the same edge out clears, so the minimum accept spacing is PULSE_LEN+1 cycles.
  - Requests arriving during PULSE are not accepted; the source must hold in_valid.
- Scan mode (10):
  - From IDLE or HOLD with mode = 10 and en = 1: next edge out = onehot(0), counter = PULSE_LEN-1 → SCAN.
  - Each position dwells PULSE_LEN cycles, then out advances to the next index.
  - Index OUT_W-1 wraps to 0 with no gap. sel and in_valid are ignored.
- Mode change:
  - Sampled every cycle.
  - Leaving SCAN (mode != 10): next edge out = 0 → IDLE; takes effect immediately, mid-dwell.
  - mode change in PULSE: the pulse completes before the new mode is honoured.
  - mode change in HOLD to 01: out retains its value until the next accept.
  - mode change in HOLD to 10: enters SCAN as above.
- en = 0: next edge out = 0, counter = 0 → IDLE, in_ready = 0; overrides all other events. Re-asserting en resumes from IDLE.
- Simultaneous events:
  - Accept and mode change on the same edge: the accept uses the mode sampled on that edge.
  - en = 0 and in_valid on the same edge: no accept.
- out_idx and out_active are registered alongside out and always consistent with it.

Test Plan:
- Reset/latch: rst_n low mid-HOLD with out = 8'h20 → out, out_idx and in_ready go 0 immediately. After release, mode 00, sel = 5, valid one cycle → out = 8'h20 next edge, held 10 cycles; then sel = 2 → out = 8'h04, no zero cycle.
- Exhaustive latch: SEL_W = 3, sel 0..7, one per cycle → out = 8'h01, 02, 04 … 80 on consecutive edges; out_idx matches sel.
- Pulse: mode 01, PULSE_LEN = 4, sel = 3 with in_valid held → out = 8'h08 for exactly 4 cycles, in_ready low for those 4. A second accept occurs on cycle 5 and out goes high again on cycle 6.
- Scan/wrap: mode 10, PULSE_LEN = 2 → out sequence 01,01,02,02 … 80,80,01; switching mode to 00 mid-dwell → out = 0 next edge.
- Enable and interrupts: en dropped during PULSE with counter = 2 → out = 0 next edge, in_ready = 0. en raised → IDLE; mode 01, sel = 1 → full 4-cycle pulse of 8'h02.
- Parametric: SEL_W = 4, PULSE_LEN = 1 scan → 16-bit out walks 0x0001 … 0x8000 one position per cycle, then wraps to 0x0001.

Source files
------------

// File: rtl/decoder_onehot_seq.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with valid/ready input and latch, pulse and scan modes.
// Latency: 1 cycle from accepting edge to out; in_ready is registered and low while pulsing or scanning.
module decoder_onehot_seq #(
  parameter int SEL_W     = 3,
  parameter int PULSE_LEN = 4,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [(1<<SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        out_idx,
  output logic                    out_active
);

  localparam int OUT_W = 1 << SEL_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {IDLE, HOLD, PULSE, SCAN} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SEL_W-1:0]  idx_nxt;
  logic              active_nxt;
  logic [OUT_W-1:0]  out_nxt;
  logic              ready_nxt;
  logic              mode_scan, mode_pulse, accept;

  assign mode_scan  = (mode == 2'b10);
  assign mode_pulse = (mode == 2'b01);
  assign accept     = in_valid && in_ready;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    idx_nxt    = out_idx;
    active_nxt = out_active;
    if (!en) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      idx_nxt    = '0;
      active_nxt = 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          // Scan entry wins over a pending request: sel is ignored in scan mode.
          if (mode_scan) begin
            state_nxt  = SCAN;
            cnt_nxt    = CNT_LOAD;
            idx_nxt    = '0;
            active_nxt = 1'b1;
          end else if (accept) begin
            idx_nxt    = sel;
            active_nxt = 1'b1;
            if (mode_pulse) begin
              state_nxt = PULSE;
              cnt_nxt   = CNT_LOAD;
            end else begin
              state_nxt = HOLD;
            end
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state_nxt  = IDLE;
            idx_nxt    = '0;
            active_nxt = 1'b0;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        SCAN: begin
          if (!mode_scan) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            idx_nxt    = '0;
            active_nxt = 1'b0;
          end else if (cnt == '0) begin
            idx_nxt = out_idx + 1'b1;
            cnt_nxt = CNT_LOAD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: begin
          state_nxt  = IDLE;
          cnt_nxt    = '0;
          idx_nxt    = '0;
          active_nxt = 1'b0;
        end
      endcase
    end
    out_nxt   = active_nxt ? (OUT_W'(1) << idx_nxt) : '0;
    ready_nxt = en && !mode_scan && ((state_nxt == IDLE) || (state_nxt == HOLD));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      out        <= '0;
      out_idx    <= '0;
      out_active <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      out        <= out_nxt;
      out_idx    <= idx_nxt;
      out_active <= active_nxt;
      in_ready   <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_onehot_seq.sv
// Directed bench for decoder_onehot_seq: default instance plus two scan-only parameter variants.
module tb_decoder_onehot_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [2:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out;
  logic [2:0]  out_idx;
  logic        out_active;

  logic        en_s;
  logic [1:0]  mode_s1, mode_s2;
  logic [2:0]  sel_s1;
  logic [3:0]  sel_s2;
  logic        valid_s;
  logic        ready1, ready2, active1, active2;
  logic [7:0]  out1;
  logic [2:0]  idx1;
  logic [15:0] out2;
  logic [3:0]  idx2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  decoder_onehot_seq u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out(out), .out_idx(out_idx), .out_active(out_active)
  );

  decoder_onehot_seq #(.SEL_W(3), .PULSE_LEN(2)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en_s), .mode(mode_s1), .sel(sel_s1), .in_valid(valid_s),
    .in_ready(ready1), .out(out1), .out_idx(idx1), .out_active(active1)
  );

  decoder_onehot_seq #(.SEL_W(4), .PULSE_LEN(1)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en_s), .mode(mode_s2), .sel(sel_s2), .in_valid(valid_s),
    .in_ready(ready2), .out(out2), .out_idx(idx2), .out_active(active2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 2'b00; sel = '0; in_valid = 1'b0;
    en_s = 1'b1; mode_s1 = 2'b00; mode_s2 = 2'b00; sel_s1 = '0; sel_s2 = '0; valid_s = 1'b0;
    #3;
    tests++;
    if (out !== 8'h00 || out_idx !== 3'd0 || out_active !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: out=%h idx=%0d act=%b rdy=%b, want 00/0/0/0", out, out_idx, out_active, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out !== 8'h00) begin
      fails++;
      $display("FAIL ready_after_reset: rdy=%b out=%h, want 1/00", in_ready, out);
    end
  endtask

  task automatic test_latch();
    sel = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; sel = 3'd0;
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (out !== 8'h20 || out_idx !== 3'd5 || out_active !== 1'b1) begin
        fails++;
        $display("FAIL latch_hold[%0d]: out=%h idx=%0d act=%b, want 20/5/1", i, out, out_idx, out_active);
      end
      tick();
    end
    sel = 3'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out !== 8'h04 || out_idx !== 3'd2) begin
      fails++;
      $display("FAIL latch_replace: out=%h idx=%0d, want 04/2", out, out_idx);
    end
  endtask

  task automatic test_reset_mid_hold();
    sel = 3'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tests++;
    if (out !== 8'h20) begin
      fails++;
      $display("FAIL pre_reset_hold: out=%h, want 20", out);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out !== 8'h00 || out_idx !== 3'd0 || out_active !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: out=%h idx=%0d act=%b rdy=%b, want 00/0/0/0", out, out_idx, out_active, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out !== 8'h00) begin
      fails++;
      $display("FAIL ready_after_rerelease: rdy=%b out=%h, want 1/00", in_ready, out);
    end
  endtask

  task automatic test_exhaustive();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i); in_valid = 1'b1;
      tick();
      exp = 8'h01 << i;
      tests++;
      if (out !== exp || out_idx !== 3'(i) || out_active !== 1'b1) begin
        fails++;
        $display("FAIL exhaustive[%0d]: out=%h idx=%0d, want %h/%0d", i, out, out_idx, exp, i);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_pulse();
    mode = 2'b01; sel = 3'd3; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (out !== 8'h08 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL pulse_high[%0d]: out=%h rdy=%b, want 08/0", i, out, in_ready);
      end
    end
    tick();
    tests++;
    if (out !== 8'h00 || in_ready !== 1'b1 || out_active !== 1'b0) begin
      fails++;
      $display("FAIL pulse_end: out=%h rdy=%b act=%b, want 00/1/0", out, in_ready, out_active);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if (out !== 8'h08 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL pulse_second: out=%h rdy=%b, want 08/0", out, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (out !== 8'h08) begin
        fails++;
        $display("FAIL pulse_second_high[%0d]: out=%h, want 08", i, out);
      end
    end
    tick();
    tests++;
    if (out !== 8'h00 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL pulse_second_end: out=%h rdy=%b, want 00/1", out, in_ready);
    end
  endtask

  task automatic test_enable();
    sel = 3'd6; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    en = 1'b0;
    tick();
    tests++;
    if (out !== 8'h00 || in_ready !== 1'b0 || out_active !== 1'b0) begin
      fails++;
      $display("FAIL en_drop_pulse: out=%h rdy=%b act=%b, want 00/0/0", out, in_ready, out_active);
    end
    en = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1 || out !== 8'h00) begin
      fails++;
      $display("FAIL en_resume: rdy=%b out=%h, want 1/00", in_ready, out);
    end
    en = 1'b0; sel = 3'd7; in_valid = 1'b1;
    tick();
    tests++;
    if (out !== 8'h00 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL en_low_no_accept: out=%h rdy=%b, want 00/0", out, in_ready);
    end
    en = 1'b1; in_valid = 1'b0;
    tick();
    sel = 3'd1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out !== 8'h02 || out_idx !== 3'd1) begin
        fails++;
        $display("FAIL en_pulse[%0d]: out=%h idx=%0d, want 02/1", i, out, out_idx);
      end
      tick();
    end
    tests++;
    if (out !== 8'h00 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL en_pulse_end: out=%h rdy=%b, want 00/1", out, in_ready);
    end
  endtask

  task automatic test_mode_change();
    mode = 2'b00; sel = 3'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; mode = 2'b01;
    tick();
    tick();
    tests++;
    if (out !== 8'h10 || out_idx !== 3'd4) begin
      fails++;
      $display("FAIL hold_to_pulse_retain: out=%h idx=%0d, want 10/4", out, out_idx);
    end
    mode = 2'b10;
    tick();
    tests++;
    if (out !== 8'h01 || out_idx !== 3'd0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL hold_to_scan: out=%h idx=%0d rdy=%b, want 01/0/0", out, out_idx, in_ready);
    end
    mode = 2'b00;
    tick();
    tests++;
    if (out !== 8'h00 || out_active !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL scan_exit: out=%h act=%b rdy=%b, want 00/0/1", out, out_active, in_ready);
    end
  endtask

  task automatic test_scan_wrap();
    logic [7:0] exp;
    mode_s1 = 2'b10;
    for (int k = 0; k <= 16; k++) begin
      tick();
      exp = 8'h01 << ((k / 2) % 8);
      tests++;
      if (out1 !== exp || idx1 !== 3'((k / 2) % 8)) begin
        fails++;
        $display("FAIL scan_wrap[%0d]: out=%h idx=%0d, want %h", k, out1, idx1, exp);
      end
    end
    mode_s1 = 2'b00;
    tick();
    tests++;
    if (out1 !== 8'h00 || active1 !== 1'b0) begin
      fails++;
      $display("FAIL scan_mid_dwell_exit: out=%h act=%b, want 00/0", out1, active1);
    end
  endtask

  task automatic test_param_scan();
    logic [15:0] exp;
    mode_s2 = 2'b10;
    for (int k = 0; k <= 16; k++) begin
      tick();
      exp = 16'h0001 << (k % 16);
      tests++;
      if (out2 !== exp || idx2 !== 4'(k % 16) || active2 !== 1'b1) begin
        fails++;
        $display("FAIL param_scan[%0d]: out=%h idx=%0d, want %h", k, out2, idx2, exp);
      end
    end
    mode_s2 = 2'b00;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_latch();
    test_reset_mid_hold();
    test_exhaustive();
    test_pulse();
    test_enable();
    test_mode_change();
    test_scan_wrap();
    test_param_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
